// File: rtl/exibicao_resultado_7seg_pkg.sv
// Shared constants for the result display: widths, base codes, FSM states and glyphs.
// Glyphs are kept in active-high form; polarity is applied only at the output stage.
package pacote_exibicao;

  localparam int LARGURA_VALOR = 8;
  localparam int NUM_DIG       = 6;

  localparam logic [1:0] BASE_DEC_U = 2'b00;
  localparam logic [1:0] BASE_DEC_S = 2'b01;
  localparam logic [1:0] BASE_HEX   = 2'b10;
  localparam logic [1:0] BASE_OCT   = 2'b11;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    ATUALIZA = 2'd2
  } estado_t;

  localparam logic [6:0] SEG_APAGADO = 7'h00;
  localparam logic [6:0] SEG_MENOS   = 7'h40;

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational nibble-to-glyph decoder (active-high, bit6=g .. bit0=a).
// The minus request takes priority over blanking.
module decodificador_7seg
  import pacote_exibicao::*;
(
  input  logic [3:0] nibble,
  input  logic       apagar,
  input  logic       menos,
  output logic [6:0] segmentos
);

  always_comb begin
    segmentos = SEG_APAGADO;
    if (menos) begin
      segmentos = SEG_MENOS;
    end else if (!apagar) begin
      case (nibble)
        4'h0: segmentos = 7'h3F;
        4'h1: segmentos = 7'h06;
        4'h2: segmentos = 7'h5B;
        4'h3: segmentos = 7'h4F;
        4'h4: segmentos = 7'h66;
        4'h5: segmentos = 7'h6D;
        4'h6: segmentos = 7'h7D;
        4'h7: segmentos = 7'h07;
        4'h8: segmentos = 7'h7F;
        4'h9: segmentos = 7'h6F;
        4'hA: segmentos = 7'h77;
        4'hB: segmentos = 7'h7C;
        4'hC: segmentos = 7'h39;
        4'hD: segmentos = 7'h5E;
        4'hE: segmentos = 7'h79;
        default: segmentos = 7'h71;
      endcase
    end
  end

endmodule

// File: rtl/exibicao_resultado_7seg.sv
// Formats the 8-bit result in unsigned/signed decimal, hex or octal onto six HEX displays.
// Decimal goes through an iterative double-dabble (one shift per clock) before the displays update.
module exibicao_resultado_7seg
  import pacote_exibicao::*;
#(
  parameter bit SEG_ATIVO_BAIXO = 1'b1,
  parameter bit APAGAR_ZEROS    = 1'b1
)
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LARGURA_VALOR-1:0] valor,
  input  logic [1:0]               base,
  input  logic                     atualizar,
  output logic                     ocupado,
  output logic                     pronto,
  output logic [6:0]               hex0,
  output logic [6:0]               hex1,
  output logic [6:0]               hex2,
  output logic [6:0]               hex3,
  output logic [6:0]               hex4,
  output logic [6:0]               hex5
);

  estado_t            estado_reg;
  logic               pendente_reg;
  logic               pronto_reg;
  logic [3:0]         cnt_reg;
  logic [19:0]        desloc_reg;
  logic [19:0]        ajustado;
  logic [1:0]         base_reg;
  logic [7:0]         valor_reg;
  logic               sinal_reg;
  logic [6:0]         seg_reg   [NUM_DIG];
  logic [6:0]         glifo     [NUM_DIG];
  logic [6:0]         seg_saida [NUM_DIG];
  logic [3:0]         digito    [NUM_DIG];
  logic [NUM_DIG-1:0] apagar;
  logic [NUM_DIG-1:0] menos;

  logic       capt_sinal;
  logic [7:0] capt_mag;
  logic       capt_dec;
  logic       carrega;
  logic [3:0] bcd_c, bcd_d, bcd_u;
  logic       mostra2, mostra1;

  // Magnitude of a negative two's-complement value; 8'h80 wraps to 128 unsigned.
  assign capt_sinal = (base == BASE_DEC_S) && valor[7];
  assign capt_mag   = capt_sinal ? (~valor + 8'd1) : valor;
  assign capt_dec   = (base == BASE_DEC_U) || (base == BASE_DEC_S);
  assign carrega    = ((estado_reg == OCIOSO) && atualizar) ||
                      ((estado_reg == ATUALIZA) && (pendente_reg || atualizar));

  assign ajustado[7:0] = desloc_reg[7:0];
  for (genvar gi = 0; gi < 3; gi++) begin : g_add3
    assign ajustado[8+4*gi +: 4] = (desloc_reg[8+4*gi +: 4] >= 4'd5) ?
                                   desloc_reg[8+4*gi +: 4] + 4'd3 :
                                   desloc_reg[8+4*gi +: 4];
  end

  assign bcd_c   = desloc_reg[19:16];
  assign bcd_d   = desloc_reg[15:12];
  assign bcd_u   = desloc_reg[11:8];
  assign mostra2 = !APAGAR_ZEROS || (bcd_c != 4'd0);
  assign mostra1 = mostra2 || (bcd_d != 4'd0);

  always_comb begin
    for (int i = 0; i < NUM_DIG; i++) begin
      digito[i] = 4'd0;
    end
    apagar = '1;
    menos  = '0;
    case (base_reg)
      BASE_HEX: begin
        digito[1] = valor_reg[7:4];
        digito[0] = valor_reg[3:0];
        apagar[1:0] = 2'b00;
      end
      BASE_OCT: begin
        digito[2] = {2'b00, valor_reg[7:6]};
        digito[1] = {1'b0, valor_reg[5:3]};
        digito[0] = {1'b0, valor_reg[2:0]};
        apagar[2:0] = 3'b000;
      end
      default: begin
        digito[2] = bcd_c;
        digito[1] = bcd_d;
        digito[0] = bcd_u;
        apagar[2] = !mostra2;
        apagar[1] = !mostra1;
        apagar[0] = 1'b0;
        // Sign sits immediately left of the most significant shown digit.
        if (sinal_reg) begin
          if (mostra2)      menos[3] = 1'b1;
          else if (mostra1) menos[2] = 1'b1;
          else              menos[1] = 1'b1;
        end
      end
    endcase
  end

  for (genvar gi = 0; gi < NUM_DIG; gi++) begin : g_dig
    decodificador_7seg u_dec (
      .nibble    (digito[gi]),
      .apagar    (apagar[gi]),
      .menos     (menos[gi]),
      .segmentos (glifo[gi])
    );
    assign seg_saida[gi] = SEG_ATIVO_BAIXO ? ~seg_reg[gi] : seg_reg[gi];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_reg   <= OCIOSO;
      pendente_reg <= 1'b0;
      pronto_reg   <= 1'b0;
      cnt_reg      <= 4'd0;
      desloc_reg   <= 20'd0;
      base_reg     <= BASE_DEC_U;
      valor_reg    <= 8'd0;
      sinal_reg    <= 1'b0;
      for (int i = 0; i < NUM_DIG; i++) begin
        seg_reg[i] <= SEG_APAGADO;
      end
    end else begin
      pronto_reg <= 1'b0;
      case (estado_reg)
        CONVERTE: begin
          desloc_reg <= {ajustado[18:0], 1'b0};
          cnt_reg    <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) estado_reg <= ATUALIZA;
          if (atualizar) pendente_reg <= 1'b1;
        end
        ATUALIZA: begin
          for (int i = 0; i < NUM_DIG; i++) begin
            seg_reg[i] <= glifo[i];
          end
          pronto_reg   <= 1'b1;
          pendente_reg <= 1'b0;
          estado_reg   <= OCIOSO;
        end
        default: ;
      endcase
      // A new capture overrides the state transition chosen above.
      if (carrega) begin
        base_reg   <= base;
        valor_reg  <= valor;
        sinal_reg  <= capt_sinal;
        desloc_reg <= {12'h000, capt_mag};
        cnt_reg    <= 4'd8;
        estado_reg <= capt_dec ? CONVERTE : ATUALIZA;
      end
    end
  end

  assign ocupado = (estado_reg != OCIOSO);
  assign pronto  = pronto_reg;
  assign hex0    = seg_saida[0];
  assign hex1    = seg_saida[1];
  assign hex2    = seg_saida[2];
  assign hex3    = seg_saida[3];
  assign hex4    = seg_saida[4];
  assign hex5    = seg_saida[5];

endmodule

// File: tb/tb_exibicao_resultado_7seg.sv
// Bench for exibicao_resultado_7seg: directed and random transactions against an arithmetic model.
// A second instance with leading-zero blanking disabled shares all inputs.
module tb_exibicao_resultado_7seg;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] valor;
  logic [1:0] base;
  logic       atualizar;
  logic       ocupado, pronto, ocupado_b, pronto_b;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [6:0] hb0, hb1, hb2, hb3, hb4, hb5;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exibicao_resultado_7seg #(.SEG_ATIVO_BAIXO(1'b1), .APAGAR_ZEROS(1'b1)) dut (
    .clk(clk), .reset(reset), .valor(valor), .base(base), .atualizar(atualizar),
    .ocupado(ocupado), .pronto(pronto),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  exibicao_resultado_7seg #(.SEG_ATIVO_BAIXO(1'b1), .APAGAR_ZEROS(1'b0)) dut_b (
    .clk(clk), .reset(reset), .valor(valor), .base(base), .atualizar(atualizar),
    .ocupado(ocupado_b), .pronto(pronto_b),
    .hex0(hb0), .hex1(hb1), .hex2(hb2), .hex3(hb3), .hex4(hb4), .hex5(hb5)
  );

  function automatic logic [41:0] tela_a();
    return {hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  function automatic logic [41:0] tela_b();
    return {hb5, hb4, hb3, hb2, hb1, hb0};
  endfunction

  // Active-low glyph table indexed by digit value.
  function automatic logic [6:0] glifo(input int d);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[d];
  endfunction

  function automatic logic [41:0] modelo(input logic [7:0] v, input logic [1:0] b, input bit az);
    logic [5:0][6:0] e;
    int vi, m, ms;
    bit neg;
    vi = int'(v);
    for (int i = 0; i < 6; i++) e[i] = 7'h7F;
    if (b == 2'd2) begin
      e[1] = glifo(vi / 16);
      e[0] = glifo(vi % 16);
    end else if (b == 2'd3) begin
      e[2] = glifo(vi / 64);
      e[1] = glifo((vi / 8) % 8);
      e[0] = glifo(vi % 8);
    end else begin
      neg = (b == 2'd1) && (vi >= 128);
      m = neg ? 256 - vi : vi;
      if (!az || m >= 100) ms = 2;
      else if (m >= 10)    ms = 1;
      else                 ms = 0;
      e[0] = glifo(m % 10);
      if (ms >= 1) e[1] = glifo((m / 10) % 10);
      if (ms >= 2) e[2] = glifo(m / 100);
      if (neg) e[ms + 1] = 7'h3F;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses atualizar for one edge, waits for pronto, then checks latency and both displays.
  task automatic transacao(input logic [7:0] v, input logic [1:0] b, input string tag);
    int lat;
    int lat_esp;
    lat = 0;
    lat_esp = (b < 2'd2) ? 9 : 1;
    valor = v; base = b; atualizar = 1'b1;
    tick();
    atualizar = 1'b0;
    chk({tag, "_ocupado_on"}, 64'(ocupado), 64'd1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (pronto) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latencia"}, 64'(lat), 64'(lat_esp));
    chk({tag, "_tela"}, 64'(tela_a()), 64'(modelo(v, b, 1'b1)));
    chk({tag, "_tela_az0"}, 64'(tela_b()), 64'(modelo(v, b, 1'b0)));
    chk({tag, "_ocupado_off"}, 64'(ocupado), 64'd0);
    tick();
    chk({tag, "_pronto_pulso"}, 64'(pronto), 64'd0);
    $display("txn %s valor=%02h base=%0d lat=%0d hex=%h", tag, v, b, lat, tela_a());
  endtask

  initial begin
    logic [7:0] rv;
    logic [1:0] rb;
    reset = 1'b1; valor = 8'd0; base = 2'd0; atualizar = 1'b0;
    #1;
    chk("reset_tela", 64'(tela_a()), {22'd0, {6{7'h7F}}});
    chk("reset_ocupado", 64'(ocupado), 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Directed values with literal expectations.
    transacao(8'd200, 2'd0, "dec200");
    chk("dec200_lit", 64'(tela_a()), {22'd0, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h40, 7'h40});
    transacao(8'd0, 2'd0, "dec0");
    transacao(8'h80, 2'd1, "neg128");
    chk("neg128_lit", 64'(tela_a()), {22'd0, 7'h7F, 7'h7F, 7'h3F, 7'h79, 7'h24, 7'h00});
    transacao(8'hFF, 2'd1, "neg1");
    chk("neg1_lit", 64'(tela_a()), {22'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h79});
    transacao(8'hAF, 2'd2, "hexAF");
    chk("hexAF_lit", 64'(tela_a()), {22'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h0E});
    transacao(8'hFF, 2'd3, "oct377");
    transacao(8'd5, 2'd0, "dec5");
    chk("dec5_az0_lit", 64'(tela_b()), {22'd0, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h12});

    // Queued request, one-deep: third request dropped.
    valor = 8'd200; base = 2'd0; atualizar = 1'b1;
    tick();                                  // edge N
    atualizar = 1'b0;
    tick(); tick();                          // N+1, N+2
    valor = 8'd7; atualizar = 1'b1;
    tick();                                  // N+3
    atualizar = 1'b0;
    tick();                                  // N+4
    valor = 8'd99; atualizar = 1'b1;
    tick();                                  // N+5
    valor = 8'd7; atualizar = 1'b0;
    tick(); tick(); tick();                  // N+6..N+8
    chk("fila_pronto_cedo", 64'(pronto), 64'd0);
    tick();                                  // N+9
    chk("fila_pronto1", 64'(pronto), 64'd1);
    chk("fila_tela1", 64'(tela_a()), 64'(modelo(8'd200, 2'd0, 1'b1)));
    chk("fila_ocupado_reinicio", 64'(ocupado), 64'd1);
    for (int i = 0; i < 8; i++) tick();      // N+10..N+17
    chk("fila_pronto_meio", 64'(pronto), 64'd0);
    tick();                                  // N+18
    chk("fila_pronto2", 64'(pronto), 64'd1);
    chk("fila_tela2", 64'(tela_a()), 64'(modelo(8'd7, 2'd0, 1'b1)));
    chk("fila_descartada", 64'(ocupado), 64'd0);
    $display("txn fila hex=%h", tela_a());
    tick();

    // Inputs changing mid-conversion without a request are ignored.
    valor = 8'd5; base = 2'd0; atualizar = 1'b1;
    tick();
    atualizar = 1'b0;
    tick(); tick();
    valor = 8'd123; base = 2'd2;
    for (int i = 0; i < 7; i++) tick();
    chk("captura_pronto", 64'(pronto), 64'd1);
    chk("captura_tela", 64'(tela_a()), 64'(modelo(8'd5, 2'd0, 1'b1)));
    chk("captura_tela_az0", 64'(tela_b()), {22'd0, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h12});
    $display("txn captura hex=%h", tela_a());
    tick();

    // Randomized transactions against the model.
    for (int n = 0; n < 24; n++) begin
      rv = 8'($urandom_range(0, 255));
      rb = 2'($urandom_range(0, 3));
      transacao(rv, rb, "rnd");
    end

    // Asynchronous reset in the middle of a conversion.
    valor = 8'd77; base = 2'd1; atualizar = 1'b1;
    tick();
    atualizar = 1'b0;
    tick(); tick();
    #3 reset = 1'b1;
    #1;
    chk("reset_meio_tela", 64'(tela_a()), {22'd0, {6{7'h7F}}});
    chk("reset_meio_ocupado", 64'(ocupado), 64'd0);
    chk("reset_meio_pronto", 64'(pronto), 64'd0);
    $display("txn reset_meio hex=%h", tela_a());
    tick();
    reset = 1'b0;
    tick();
    transacao(8'd42, 2'd0, "pos_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
